// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_unit
// Description : Hazard detection and forwarding control for a 5-stage MIPS
//               pipeline. Tracks the M/W destination fields internally,
//               drives execute/decode forward selects and the fetch/decode
//               stall plus execute flush, and counts stall cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_unit #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int FWD_WIDTH      = 2,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [REG_ADDR_WIDTH-1:0] RsD,
    input  logic [REG_ADDR_WIDTH-1:0] RtD,
    input  logic                      BranchD,
    input  logic [REG_ADDR_WIDTH-1:0] RsE,
    input  logic [REG_ADDR_WIDTH-1:0] RtE,
    input  logic [REG_ADDR_WIDTH-1:0] WriteRegE,
    input  logic                      RegWriteE,
    input  logic                      MemtoRegE,
    input  logic                      CountClr,
    output logic [FWD_WIDTH-1:0]      ForwardAE,
    output logic [FWD_WIDTH-1:0]      ForwardBE,
    output logic                      ForwardAD,
    output logic                      ForwardBD,
    output logic                      StallF,
    output logic                      StallD,
    output logic                      FlushE,
    output logic [CNT_WIDTH-1:0]      StallCount
);

    // Forward-select encodings for the execute-stage 4:1 muxes (11 unused)
    localparam logic [FWD_WIDTH-1:0] C_FWD_RF = '0;
    localparam logic [FWD_WIDTH-1:0] C_FWD_W  = FWD_WIDTH'(1);
    localparam logic [FWD_WIDTH-1:0] C_FWD_M  = FWD_WIDTH'(2);

    // Pipeline-tracking flops (shadow copies of the M and W stage fields)
    logic [REG_ADDR_WIDTH-1:0] write_reg_m_q, write_reg_m_d;
    logic                      reg_write_m_q, reg_write_m_d;
    logic                      mem_to_reg_m_q, mem_to_reg_m_d;
    logic [REG_ADDR_WIDTH-1:0] write_reg_w_q, write_reg_w_d;
    logic                      reg_write_w_q, reg_write_w_d;
    logic [CNT_WIDTH-1:0]      stall_count_q, stall_count_d;

    // Hit terms; register $0 never matches
    logic w_m_hit_rs_e, w_m_hit_rt_e, w_w_hit_rs_e, w_w_hit_rt_e;
    logic w_m_hit_rs_d, w_m_hit_rt_d, w_e_hit_rs_d, w_e_hit_rt_d;
    logic w_lw_stall, w_branch_stall, w_stall;

    // Next-state of the tracking flops: they follow the pipeline unconditionally
    always_comb begin
        write_reg_m_d  = WriteRegE;
        reg_write_m_d  = RegWriteE;
        mem_to_reg_m_d = MemtoRegE;
        write_reg_w_d  = write_reg_m_q;
        reg_write_w_d  = reg_write_m_q;
    end

    // Tracking flops with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RST) begin
            write_reg_m_q  <= '0;
            reg_write_m_q  <= 1'b0;
            mem_to_reg_m_q <= 1'b0;
            write_reg_w_q  <= '0;
            reg_write_w_q  <= 1'b0;
        end else begin
            write_reg_m_q  <= write_reg_m_d;
            reg_write_m_q  <= reg_write_m_d;
            mem_to_reg_m_q <= mem_to_reg_m_d;
            write_reg_w_q  <= write_reg_w_d;
            reg_write_w_q  <= reg_write_w_d;
        end
    end

    // Register-match detection against the E, M and W producers
    always_comb begin
        w_m_hit_rs_e = (RsE != '0) && (RsE == write_reg_m_q) && reg_write_m_q;
        w_m_hit_rt_e = (RtE != '0) && (RtE == write_reg_m_q) && reg_write_m_q;
        w_w_hit_rs_e = (RsE != '0) && (RsE == write_reg_w_q) && reg_write_w_q;
        w_w_hit_rt_e = (RtE != '0) && (RtE == write_reg_w_q) && reg_write_w_q;
        w_m_hit_rs_d = (RsD != '0) && (RsD == write_reg_m_q) && reg_write_m_q;
        w_m_hit_rt_d = (RtD != '0) && (RtD == write_reg_m_q) && reg_write_m_q;
        w_e_hit_rs_d = (RsD != '0) && (RsD == WriteRegE) && RegWriteE;
        w_e_hit_rt_d = (RtD != '0) && (RtD == WriteRegE) && RegWriteE;
    end

    // Load-use and branch-operand stall decisions
    always_comb begin
        w_lw_stall     = MemtoRegE && RegWriteE && (WriteRegE != '0) &&
                         ((WriteRegE == RsD) || (WriteRegE == RtD));
        w_branch_stall = BranchD &&
                         (w_e_hit_rs_d || w_e_hit_rt_d ||
                          (mem_to_reg_m_q && (w_m_hit_rs_d || w_m_hit_rt_d)));
        w_stall        = w_lw_stall || w_branch_stall;
    end

    // Output decode; everything is held low while reset is asserted
    always_comb begin
        ForwardAE  = C_FWD_RF;
        ForwardBE  = C_FWD_RF;
        ForwardAD  = 1'b0;
        ForwardBD  = 1'b0;
        StallF     = 1'b0;
        StallD     = 1'b0;
        FlushE     = 1'b0;
        StallCount = '0;
        if (RST) begin
            // M is the younger producer, so it wins over W
            if (w_m_hit_rs_e)      ForwardAE = C_FWD_M;
            else if (w_w_hit_rs_e) ForwardAE = C_FWD_W;
            if (w_m_hit_rt_e)      ForwardBE = C_FWD_M;
            else if (w_w_hit_rt_e) ForwardBE = C_FWD_W;
            ForwardAD  = w_m_hit_rs_d;
            ForwardBD  = w_m_hit_rt_d;
            StallF     = w_stall;
            StallD     = w_stall;
            FlushE     = w_stall;
            StallCount = stall_count_q;
        end
    end

    // Saturating stall counter next-state: clear wins over increment
    always_comb begin
        stall_count_d = stall_count_q;
        if (CountClr)
            stall_count_d = '0;
        else if (StallD && (stall_count_q != '1))
            stall_count_d = stall_count_q + CNT_WIDTH'(1);
    end

    // Stall counter flop
    always_ff @(posedge CLK) begin
        if (!RST) stall_count_q <= '0;
        else      stall_count_q <= stall_count_d;
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_unit
// Description : Self-checking bench for hazard_unit. A reference model
//               predicts every output per cycle into a scoreboard queue that
//               is drained against the DUT on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_unit;

    localparam int C_RW = 5;
    localparam int C_FW = 2;
    localparam int C_CW = 4;

    logic            clk;
    logic            rst_n;
    logic [C_RW-1:0] rs_d, rt_d, rs_e, rt_e, wr_e;
    logic            branch_d, rw_e, mtr_e, cnt_clr;
    logic [C_FW-1:0] fwd_ae, fwd_be;
    logic            fwd_ad, fwd_bd, stall_f, stall_d, flush_e;
    logic [C_CW-1:0] stall_count;

    typedef struct {
        logic [1:0] fae;
        logic [1:0] fbe;
        logic       fad;
        logic       fbd;
        logic       stall;
        logic [3:0] cnt;
    } exp_t;

    exp_t sb_q[$];

    // Reference model state (M/W shadow and counter)
    logic [C_RW-1:0] m_wr, w_wr;
    logic            m_rw, m_mtr, w_rw;
    logic [C_CW-1:0] m_cnt;

    int n_vectors     = 0;
    int n_miscompares = 0;

    hazard_unit #(
        .REG_ADDR_WIDTH (C_RW),
        .FWD_WIDTH      (C_FW),
        .CNT_WIDTH      (C_CW)
    ) u_dut (
        .CLK        (clk),
        .RST        (rst_n),
        .RsD        (rs_d),
        .RtD        (rt_d),
        .BranchD    (branch_d),
        .RsE        (rs_e),
        .RtE        (rt_e),
        .WriteRegE  (wr_e),
        .RegWriteE  (rw_e),
        .MemtoRegE  (mtr_e),
        .CountClr   (cnt_clr),
        .ForwardAE  (fwd_ae),
        .ForwardBE  (fwd_be),
        .ForwardAD  (fwd_ad),
        .ForwardBD  (fwd_bd),
        .StallF     (stall_f),
        .StallD     (stall_d),
        .FlushE     (flush_e),
        .StallCount (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vectors++;
        if (obs !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic hit(input logic [C_RW-1:0] x, input logic [C_RW-1:0] wr, input logic rw);
        return (x != 0) && (x == wr) && rw;
    endfunction

    function automatic exp_t predict();
        exp_t e;
        logic lw, br;
        e.fae = 2'd0; e.fbe = 2'd0; e.fad = 1'b0; e.fbd = 1'b0; e.stall = 1'b0; e.cnt = 4'd0;
        if (rst_n) begin
            e.fae = hit(rs_e, m_wr, m_rw) ? 2'd2 : (hit(rs_e, w_wr, w_rw) ? 2'd1 : 2'd0);
            e.fbe = hit(rt_e, m_wr, m_rw) ? 2'd2 : (hit(rt_e, w_wr, w_rw) ? 2'd1 : 2'd0);
            e.fad = hit(rs_d, m_wr, m_rw);
            e.fbd = hit(rt_d, m_wr, m_rw);
            lw = mtr_e && rw_e && (wr_e != 0) && ((wr_e == rs_d) || (wr_e == rt_d));
            br = branch_d && (hit(rs_d, wr_e, rw_e) || hit(rt_d, wr_e, rw_e) ||
                              (m_mtr && (hit(rs_d, m_wr, m_rw) || hit(rt_d, m_wr, m_rw))));
            e.stall = lw || br;
            e.cnt   = m_cnt;
        end
        return e;
    endfunction

    task automatic set_idle();
        rs_d = '0; rt_d = '0; rs_e = '0; rt_e = '0; wr_e = '0;
        branch_d = 1'b0; rw_e = 1'b0; mtr_e = 1'b0; cnt_clr = 1'b0;
    endtask

    // Predict with the current inputs, then compare against the DUT mid-cycle
    task automatic apply_and_check(input string tag);
        exp_t e;
        sb_q.push_back(predict());
        @(negedge clk);
        e = sb_q.pop_front();
        check_value({tag, ".fae"},   32'(fwd_ae),      32'(e.fae));
        check_value({tag, ".fbe"},   32'(fwd_be),      32'(e.fbe));
        check_value({tag, ".fad"},   32'(fwd_ad),      32'(e.fad));
        check_value({tag, ".fbd"},   32'(fwd_bd),      32'(e.fbd));
        check_value({tag, ".stf"},   32'(stall_f),     32'(e.stall));
        check_value({tag, ".std"},   32'(stall_d),     32'(e.stall));
        check_value({tag, ".fle"},   32'(flush_e),     32'(e.stall));
        check_value({tag, ".cnt"},   32'(stall_count), 32'(e.cnt));
    endtask

    // Advance one clock edge and update the model state
    task automatic advance();
        exp_t e;
        e = predict();
        @(posedge clk);
        if (!rst_n) begin
            m_wr = '0; m_rw = 1'b0; m_mtr = 1'b0; w_wr = '0; w_rw = 1'b0; m_cnt = '0;
        end else begin
            w_wr = m_wr; w_rw = m_rw;
            m_wr = wr_e; m_rw = rw_e; m_mtr = mtr_e;
            if (cnt_clr)                        m_cnt = '0;
            else if (e.stall && m_cnt != 4'hF)  m_cnt = m_cnt + 4'd1;
        end
        #1;
    endtask

    initial begin
        m_wr = '0; m_rw = 1'b0; m_mtr = 1'b0; w_wr = '0; w_rw = 1'b0; m_cnt = '0;
        set_idle();
        rst_n = 1'b0;

        // Reset with hazard-causing inputs: everything low
        mtr_e = 1'b1; rw_e = 1'b1; wr_e = 5'd5; rs_d = 5'd5;
        apply_and_check("rst0");
        check_value("rst0.stall_low", 32'(stall_d), 32'd0);
        advance();
        apply_and_check("rst1");
        advance();

        // Back-to-back ALU on $8: M forward, then W forward, then none
        rst_n = 1'b1; set_idle();
        wr_e = 5'd8; rw_e = 1'b1;
        apply_and_check("alu_prod");
        advance();
        set_idle(); rs_e = 5'd8;
        apply_and_check("alu_m");
        check_value("alu_m.fae_10", 32'(fwd_ae), 32'd2);
        advance();
        apply_and_check("alu_w");
        check_value("alu_w.fae_01", 32'(fwd_ae), 32'd1);
        advance();
        apply_and_check("alu_none");
        check_value("alu_none.fae_00", 32'(fwd_ae), 32'd0);
        advance();

        // M and W both write $9: M wins
        set_idle(); wr_e = 5'd9; rw_e = 1'b1;
        apply_and_check("dbl9_a");
        advance();
        apply_and_check("dbl9_b");
        advance();
        set_idle(); rt_e = 5'd9; wr_e = 5'd0; rw_e = 1'b1; mtr_e = 1'b1;
        apply_and_check("dbl9_fwd");
        check_value("dbl9.fbe_10", 32'(fwd_be), 32'd2);
        check_value("r0_lw.nostall", 32'(stall_d), 32'd0);
        advance();
        // $0 now in M with RegWrite set: no forward on $0 source
        set_idle(); rs_e = 5'd0; rt_e = 5'd0; branch_d = 1'b1;
        apply_and_check("r0_m");
        check_value("r0_m.fae", 32'(fwd_ae), 32'd0);
        advance();

        // Load-use on $5: single stall cycle, then bubble, then W forward
        set_idle(); mtr_e = 1'b1; rw_e = 1'b1; wr_e = 5'd5; rs_d = 5'd5;
        apply_and_check("lu_stall");
        check_value("lu_stall.std", 32'(stall_d), 32'd1);
        advance();
        set_idle(); rs_d = 5'd5;
        apply_and_check("lu_bubble");
        check_value("lu_bubble.std", 32'(stall_d), 32'd0);
        advance();
        set_idle(); rs_e = 5'd5;
        apply_and_check("lu_use");
        advance();

        // Branch on $7 after a load: two stall cycles
        set_idle(); branch_d = 1'b1; rt_d = 5'd7; mtr_e = 1'b1; rw_e = 1'b1; wr_e = 5'd7;
        apply_and_check("br_ld_e");
        check_value("br_ld_e.std", 32'(stall_d), 32'd1);
        advance();
        set_idle(); branch_d = 1'b1; rt_d = 5'd7;
        apply_and_check("br_ld_m");
        check_value("br_ld_m.std", 32'(stall_d), 32'd1);
        advance();
        apply_and_check("br_ld_w");
        check_value("br_ld_w.std", 32'(stall_d), 32'd0);
        advance();

        // Branch on $7 after an ALU op: one stall, then ForwardAD from M
        set_idle(); branch_d = 1'b1; rs_d = 5'd7; rw_e = 1'b1; wr_e = 5'd7;
        apply_and_check("br_alu_e");
        check_value("br_alu_e.std", 32'(stall_d), 32'd1);
        advance();
        set_idle(); branch_d = 1'b1; rs_d = 5'd7; rt_d = 5'd7;
        apply_and_check("br_alu_m");
        check_value("br_alu_m.fad", 32'(fwd_ad), 32'd1);
        check_value("br_alu_m.fbd", 32'(fwd_bd), 32'd1);
        check_value("br_alu_m.std", 32'(stall_d), 32'd0);
        advance();

        // Counter saturation: hold a load-use stall for 20 cycles
        set_idle(); mtr_e = 1'b1; rw_e = 1'b1; wr_e = 5'd3; rs_d = 5'd3;
        for (int i = 0; i < 20; i++) begin
            apply_and_check("sat");
            advance();
        end
        apply_and_check("sat_end");
        check_value("sat_end.cnt15", 32'(stall_count), 32'd15);
        cnt_clr = 1'b1;
        advance();
        cnt_clr = 1'b0;
        apply_and_check("clr");
        check_value("clr.cnt0", 32'(stall_count), 32'd0);
        advance();

        // Reset during an active stall, then release with stale source
        set_idle(); rw_e = 1'b1; wr_e = 5'd4;
        apply_and_check("pre_rst");
        advance();
        mtr_e = 1'b1; rs_d = 5'd4; rs_e = 5'd4;
        rst_n = 1'b0;
        apply_and_check("mid_rst");
        check_value("mid_rst.stf", 32'(stall_f), 32'd0);
        check_value("mid_rst.fae", 32'(fwd_ae), 32'd0);
        advance();
        rst_n = 1'b1; set_idle(); rs_e = 5'd4;
        apply_and_check("post_rst");
        check_value("post_rst.fae", 32'(fwd_ae), 32'd0);
        check_value("post_rst.cnt", 32'(stall_count), 32'd0);
        advance();

        // Random traffic against the model
        for (int i = 0; i < 200; i++) begin
            rs_d = 5'($urandom_range(0, 3)); rt_d = 5'($urandom_range(0, 3));
            rs_e = 5'($urandom_range(0, 3)); rt_e = 5'($urandom_range(0, 3));
            wr_e = 5'($urandom_range(0, 3));
            branch_d = 1'($urandom); rw_e = 1'($urandom); mtr_e = 1'($urandom);
            cnt_clr = ($urandom_range(0, 15) == 0);
            rst_n = ($urandom_range(0, 31) != 0);
            apply_and_check("rand");
            advance();
        end

        if (sb_q.size() != 0) check_value("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
`default_nettype wire
